// File: rtl/sound_pkg.sv
// Shared types and constants for the ADSR output stage that follows the melody player.
package sound_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAttack,
      StDecay,
      StSustain,
      StRelease
   } env_state_t;

   localparam int unsigned LEVEL_BITS       = 8;
   localparam int unsigned LEVEL_MAX        = 255;
   // 1 ms envelope step at a 50 MHz system clock.
   localparam int unsigned STEP_DIV_DEFAULT = 50_000;

endpackage

// File: rtl/sound_envelope_if.sv
// Player-to-envelope signal bundle: master is the melody player side, slave the envelope.
interface sound_envelope_if;
   import sound_pkg::*;

   logic                  iTONE;
   logic                  iGATE;
   logic                  oSOUND;
   logic [LEVEL_BITS-1:0] oLEVEL;
   logic                  oBUSY;

   modport master (
      output iTONE,
      output iGATE,
      input  oSOUND,
      input  oLEVEL,
      input  oBUSY
   );

   modport slave (
      input  iTONE,
      input  iGATE,
      output oSOUND,
      output oLEVEL,
      output oBUSY
   );

endinterface

// File: rtl/sound_env_tick.sv
// Envelope step divider: one-cycle tick every STEP_DIV clocks (STEP_DIV >= 2).
module sound_env_tick
   import sound_pkg::*;
#(
   parameter int unsigned STEP_DIV = STEP_DIV_DEFAULT
) (
   input  logic iCLK,
   input  logic iRST,
   output logic oTICK
);

   localparam int unsigned   CntW    = $clog2(STEP_DIV);
   localparam logic [CntW-1:0] CntLast = CntW'(STEP_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      oTICK = (cnt_q == CntLast);
      cnt_d = oTICK ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sound_envelope.sv
// ADSR envelope applied to the player's square-wave tone through a PWM carrier.
// Define SOUND_ENVELOPE_BYPASS_EN to compile out the envelope and pass tone & gate straight through.
module sound_envelope
   import sound_pkg::*;
#(
   parameter int unsigned STEP_DIV     = STEP_DIV_DEFAULT,
   parameter int unsigned ATTACK_STEP  = 8,
   parameter int unsigned DECAY_STEP   = 2,
   parameter int unsigned SUSTAIN_LVL  = 160,
   parameter int unsigned RELEASE_STEP = 4
) (
   input logic             iCLK,
   input logic             iRST,
   sound_envelope_if.slave bus
);

   localparam logic [LEVEL_BITS-1:0] LvlMax = LEVEL_BITS'(LEVEL_MAX);

   logic tone_q, gate_q;
   logic sound_q, sound_d;

`ifdef SOUND_ENVELOPE_BYPASS_EN

   always_comb begin
      sound_d = tone_q & gate_q;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         tone_q  <= 1'b0;
         gate_q  <= 1'b0;
         sound_q <= 1'b0;
      end else begin
         tone_q  <= bus.iTONE;
         gate_q  <= bus.iGATE;
         sound_q <= sound_d;
      end
   end

   assign bus.oSOUND = sound_q;
   assign bus.oLEVEL = gate_q ? LvlMax : '0;
   assign bus.oBUSY  = gate_q;

`else

   localparam int unsigned           W9     = LEVEL_BITS + 1;
   localparam logic [LEVEL_BITS-1:0] SusLvl = LEVEL_BITS'(SUSTAIN_LVL);

   logic                  tick;
   logic                  gate_qq, rise, fall;
   logic [LEVEL_BITS-1:0] level_q, level_d, pwm_cnt_q;
   logic [W9-1:0]         sum, dec, rel;
   logic                  busy_q, busy_d;
   env_state_t            state_q, state_d;

   sound_env_tick #(
      .STEP_DIV(STEP_DIV)
   ) u_tick (
      .iCLK (iCLK),
      .iRST (iRST),
      .oTICK(tick)
   );

   always_comb begin
      rise = gate_q & ~gate_qq;
      fall = ~gate_q & gate_qq;
      // 9-bit intermediates: carry/borrow bit flags saturation.
      sum  = {1'b0, level_q} + W9'(ATTACK_STEP);
      dec  = {1'b0, level_q} - W9'(DECAY_STEP);
      rel  = {1'b0, level_q} - W9'(RELEASE_STEP);

      state_d = state_q;
      level_d = level_q;
      // Gate edges take the cycle; level is kept so a retrigger does not click.
      if (rise) begin
         state_d = StAttack;
      end else if (fall) begin
         if (state_q inside {StAttack, StDecay, StSustain}) state_d = StRelease;
      end else if (tick) begin
         case (state_q)
            StAttack: begin
               if (sum >= W9'(LEVEL_MAX)) begin
                  level_d = LvlMax;
                  state_d = StDecay;
               end else begin
                  level_d = sum[LEVEL_BITS-1:0];
               end
            end
            StDecay: begin
               if (dec[LEVEL_BITS] || (dec[LEVEL_BITS-1:0] <= SusLvl)) begin
                  level_d = SusLvl;
                  state_d = StSustain;
               end else begin
                  level_d = dec[LEVEL_BITS-1:0];
               end
            end
            StRelease: begin
               if (rel[LEVEL_BITS] || (rel[LEVEL_BITS-1:0] == '0)) begin
                  level_d = '0;
                  state_d = StIdle;
               end else begin
                  level_d = rel[LEVEL_BITS-1:0];
               end
            end
            StIdle:  level_d = '0;
            default: level_d = level_q;
         endcase
      end

      sound_d = tone_q & (pwm_cnt_q < level_q);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         tone_q    <= 1'b0;
         gate_q    <= 1'b0;
         gate_qq   <= 1'b0;
         pwm_cnt_q <= '0;
         level_q   <= '0;
         state_q   <= StIdle;
         sound_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         tone_q    <= bus.iTONE;
         gate_q    <= bus.iGATE;
         gate_qq   <= gate_q;
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
         level_q   <= level_d;
         state_q   <= state_d;
         sound_q   <= sound_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.oSOUND = sound_q;
   assign bus.oLEVEL = level_q;
   assign bus.oBUSY  = busy_q;

`endif

endmodule
